timer_ctrl: RTL

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 27 ++
 rtl/timer_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/timer_ctrl_if.sv
// CPU-side register bus of the timer: register select, write strobe and data,
// combinational read data, and the level interrupt request towards CP0.
interface timer_ctrl_if;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   // CPU side drives the bus and consumes read data / interrupt.
   modport master (
      output addr,
      output we,
      output wdata,
      input  rdata,
      input  irq
   );

   // Timer side samples the bus and produces read data / interrupt.
   modport slave (
      input  addr,
      input  we,
      input  wdata,
      output rdata,
      output irq
   );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers.
// One-shot or auto-reload operation; raises a level interrupt (IM & FLAG)
// when the count expires. CPU writes to CTRL/PRESET always take priority
// over FSM-driven updates of EN and FLAG on the same edge.
module timer_ctrl (
   input  logic        clk,
   input  logic        reset,
   timer_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   state_t      state_q;
   state_t      state_d;

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset_q;
   logic [31:0] count_q;
   logic [31:0] count_d;
   logic        flag_q;

   logic        wr_ctrl;
   logic        wr_preset;
   logic        auto_reload;
   logic        fsm_flag_set;
   logic        fsm_flag_clr;
   logic        fsm_en_clr;

   assign wr_ctrl     = bus.we && (bus.addr == ADDR_CTRL);
   assign wr_preset   = bus.we && (bus.addr == ADDR_PRESET);
   assign auto_reload = (ctrl_mode == 2'b01);

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, count update and FSM requests on EN/FLAG.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      fsm_flag_set = 1'b0;
      fsm_flag_clr = 1'b0;
      fsm_en_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ctrl_en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            count_d = preset_q;
            state_d = CNT;
         end
         CNT: begin
            if (!ctrl_en) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d      = '0;
               fsm_flag_set = 1'b1;
               state_d      = INT;
            end
         end
         INT: begin
            if (auto_reload) begin
               fsm_flag_clr = 1'b1;
               state_d      = LOAD;
            end else begin
               fsm_en_clr = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // CTRL register: CPU write beats the one-shot EN clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= '0;
         ctrl_im   <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_en   <= bus.wdata[0];
         ctrl_mode <= bus.wdata[2:1];
         ctrl_im   <= bus.wdata[3];
      end else if (fsm_en_clr) begin
         ctrl_en <= 1'b0;
      end
   end

   // PRESET register: only consumed at LOAD, so mid-count writes do not touch COUNT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         preset_q <= '0;
      end else if (wr_preset) begin
         preset_q <= bus.wdata;
      end
   end

   // COUNT register: owned entirely by the FSM, never CPU-writable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // FLAG: any CTRL/PRESET write clears it and wins over an FSM set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_q <= 1'b0;
      end else if (wr_ctrl || wr_preset) begin
         flag_q <= 1'b0;
      end else if (fsm_flag_set) begin
         flag_q <= 1'b1;
      end else if (fsm_flag_clr) begin
         flag_q <= 1'b0;
      end
   end

   assign bus.irq = ctrl_im & flag_q;

   // Zero-latency read mux; unmapped address reads as zero.
   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         ADDR_CTRL:   bus.rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         ADDR_PRESET: bus.rdata = preset_q;
         ADDR_COUNT:  bus.rdata = count_q;
         default:     bus.rdata = '0;
      endcase
   end

endmodule
